// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared state encoding, link defaults and parity helper for the serial link
package serial_tx_pkg;
  typedef enum logic [1:0] {IDLE, PRE, DATA, PAR} tx_state_t;
  localparam int PRE_W_DEF = 4;
  localparam logic [PRE_W_DEF-1:0] PREAMBLE_DEF = 4'b1101;
  localparam int DATA_W_DEF = 8;
  localparam logic IDLE_LVL_DEF = 1'b0;
  function automatic logic even_parity(input logic [DATA_W_DEF-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/tx_shift_reg.sv
// tx_shift_reg: parallel-load, shift-left register exposing its MSB, with sync clear
module tx_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] d_i,
  output logic         msb_o
);
  logic [W-1:0] sr_q;
  always_ff @(posedge clk_i)
    if (clr_i) sr_q <= '0;
    else if (load_i) sr_q <= d_i;
    else if (shift_i) sr_q <= {sr_q[W-2:0], 1'b0};
  assign msb_o = sr_q[W-1];
endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: sends preamble, payload and even parity on one registered wire per accepted word
module serial_frame_tx
  import serial_tx_pkg::*;
#(
  parameter int                 PRE_W    = PRE_W_DEF,
  parameter logic [PRE_W-1:0]   PREAMBLE = PREAMBLE_DEF,
  parameter int                 DATA_W   = DATA_W_DEF,
  parameter logic               IDLE_LVL = IDLE_LVL_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Valid,
  input  logic [DATA_W-1:0] Din,
  output logic              Ready,
  output logic              Sout,
  output logic              Busy,
  output logic              Done
);
  localparam int CNT_W = $clog2(PRE_W > DATA_W ? PRE_W : DATA_W);
  tx_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sout_q, sout_d, par_q, accept, shift, msb;
  assign Ready  = !Rst && (state_q == IDLE || state_q == PAR);
  assign accept = Valid && Ready;
  assign Busy   = state_q != IDLE;
  assign Done   = state_q == PAR;
  assign Sout   = sout_q;
  // sout_d is the bit for the coming cycle, so the shifter advances as its MSB is registered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sout_d  = IDLE_LVL;
    shift   = 1'b0;
    case (state_q)
      IDLE, PAR:
        if (accept) begin
          state_d = PRE;
          cnt_d   = CNT_W'(PRE_W - 1);
          sout_d  = PREAMBLE[PRE_W-1];
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      PRE:
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = CNT_W'(DATA_W - 1);
          sout_d  = msb;
          shift   = 1'b1;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          sout_d = 1'(PREAMBLE >> (cnt_q - 1'b1));
        end
      DATA:
        if (cnt_q == '0) begin
          state_d = PAR;
          sout_d  = par_q;
        end else begin
          cnt_d  = cnt_q - 1'b1;
          sout_d = msb;
          shift  = 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk)
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sout_q  <= IDLE_LVL;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      if (accept) par_q <= even_parity(Din);
    end
  tx_shift_reg #(.W(DATA_W)) u_shreg (
    .clk_i  (Clk),
    .clr_i  (Rst),
    .load_i (accept),
    .shift_i(shift),
    .d_i    (Din),
    .msb_o  (msb)
  );
endmodule
